// File: rtl/spi_display_regfile.sv
// spi_display_regfile: oversampled SPI-slave register file driving a multiplexed 7-segment display.
// Define SPI_READBACK_EN to add register readback on spi_miso_o.
module spi_display_regfile #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 5000
) (
    input  logic                  block_clk_i,
    input  logic                  rst_low_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_ss_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic [7:0]            segment_o,
    output logic [NUM_DIGITS-1:0] digit_o,
    output logic                  frame_err_o
);
    localparam int NR = NUM_DIGITS + 2;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [3:0] LAST_ADDR = 4'(NUM_DIGITS + 1);
    localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [2:0]  sclk_q, ss_q;
    logic [1:0]  mosi_q;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bits_q, bits_d;
    logic        ovf_q, ovf_d, done_q, done_d, err_q, err_d;
    logic [7:0]  regs_q [NR];
    logic        rise, ss_rise;
    logic [3:0]  cmd, addr;

    // [1] is the synchronised level, [2] the previous one for edge detection
    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            sclk_q <= '1;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk_i};
            ss_q   <= {ss_q[1:0], spi_ss_i};
            mosi_q <= {mosi_q[0], spi_mosi_i};
        end
    end

    assign rise    = ~sclk_q[2] & sclk_q[1] & ~ss_q[1];
    assign ss_rise = ~ss_q[2] & ss_q[1];
    assign cmd     = shift_q[15:12];
    assign addr    = shift_q[11:8];

    always_comb begin
        shift_d = shift_q;
        bits_d  = bits_q;
        ovf_d   = ovf_q;
        done_d  = rise && bits_q == 5'd15;
        err_d   = (ss_rise && bits_q != 5'd0 && bits_q != 5'd16) || (rise && bits_q == 5'd16 && !ovf_q);
        if (ss_rise) begin
            bits_d = '0;
            ovf_d  = 1'b0;
        end else if (rise) begin
            if (bits_q == 5'd16) ovf_d = 1'b1;
            else begin
                shift_d = {shift_q[14:0], mosi_q[1]};
                bits_d  = bits_q + 5'd1;
            end
        end
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            shift_q <= '0;
            bits_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bits_q  <= bits_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign frame_err_o = err_q;

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            for (int i = 0; i < NR; i++) regs_q[i] <= '0;
        end else if (done_q) begin
            if (cmd == 4'h1 && addr <= LAST_ADDR) regs_q[addr] <= shift_q[7:0];
            else if (cmd == 4'h3) for (int i = 0; i < NR; i++) regs_q[i] <= '0;
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] resp_q, tx_q;
    logic       pend_q, fall, ss_fall;
    assign fall    = sclk_q[2] & ~sclk_q[1] & ~ss_q[1];
    assign ss_fall = ss_q[2] & ~ss_q[1];
    // The leading falling edge of a mode-3 frame precedes the first sample, so shifting waits for bit 1
    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            resp_q <= '0;
            tx_q   <= '1;
            pend_q <= 1'b0;
        end else begin
            if (err_q) begin
                pend_q <= 1'b0;
                tx_q   <= '1;
            end else if (ss_fall) begin
                tx_q   <= pend_q ? resp_q : 8'hFF;
                pend_q <= 1'b0;
            end else if (ss_rise) tx_q <= '1;
            else if (fall && bits_q != 5'd0) tx_q <= {tx_q[6:0], 1'b1};
            if (done_q && cmd == 4'h2) begin
                resp_q <= addr <= LAST_ADDR ? regs_q[addr] : 8'h00;
                pend_q <= 1'b1;
            end
        end
    end
    assign spi_miso_o = tx_q[7];
`else
    assign spi_miso_o = 1'b1;
`endif

    logic [CW-1:0]         scnt_q;
    logic [IW-1:0]         idx_q;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic [3:0]            didx;
    logic                  en, wrap;

    always_comb begin
        didx  = 4'(idx_q) + 4'd1;
        en    = regs_q[0][idx_q];
        wrap  = scnt_q == CW'(SCAN_DIV - 1);
        seg_d = en ? {~regs_q[LAST_ADDR][idx_q], ~HEX7[regs_q[didx][3:0]]} : 8'hFF;
        dig_d = en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            scnt_q <= '0;
            idx_q  <= '0;
            seg_q  <= 8'hFF;
            dig_q  <= '1;
        end else begin
            scnt_q <= wrap ? '0 : scnt_q + 1'b1;
            if (wrap) idx_q <= idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
            seg_q  <= seg_d;
            dig_q  <= dig_d;
        end
    end

    assign segment_o = seg_q;
    assign digit_o   = dig_q;
endmodule

// File: tb/tb_spi_display_regfile.sv
// tb_spi_display_regfile: directed SPI frames with a frame scoreboard and a scan-phase display scoreboard.
module tb_spi_display_regfile;
    localparam int ND = 8;
    localparam int SD = 8;
`ifdef SPI_READBACK_EN
    localparam logic [31:0] RB_A7 = 32'hA7FF;
    localparam logic [31:0] RB_00 = 32'h00FF;
`else
    localparam logic [31:0] RB_A7 = 32'hFFFF;
    localparam logic [31:0] RB_00 = 32'hFFFF;
`endif

    logic          clk, rst_n, sclk, ss, mosi, miso, ferr;
    logic [7:0]    seg;
    logic [ND-1:0] dig;
    int            checks = 0, errors = 0, cyc;

    typedef struct { string name; logic [31:0] miso; int errs; } frame_t;
    typedef struct { string name; int idx; logic [7:0] dig; logic [7:0] seg; } disp_t;
    frame_t fq[$];
    disp_t  dq[$];

    spi_display_regfile #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .block_clk_i(clk), .rst_low_i(rst_n), .spi_sclk_i(sclk), .spi_ss_i(ss),
        .spi_mosi_i(mosi), .spi_miso_o(miso), .segment_o(seg), .digit_o(dig), .frame_err_o(ferr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input int n, input logic [31:0] exp_miso, input int exp_err, input string nm);
        fq.push_back('{nm, exp_miso, exp_err});
        ss = 0;
        #50;
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 0;
            mosi = w[i];
            #50;
            sclk = 1;
            #50;
        end
        ss = 1;
        #150;
    endtask

    task automatic wr(input logic [15:0] f, input string nm);
        send({16'h0, f}, 16, 32'hFFFF, 0, nm);
    endtask

    task automatic disp(input int idx, input logic [7:0] d, input logic [7:0] s, input string nm);
        dq.push_back('{nm, idx, d, s});
    endtask

    task automatic settle();
        for (int i = 0; i < 4 * SD * ND && dq.size() > 0; i++) #10;
        while (dq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: display phase never observed", dq[0].name);
            void'(dq.pop_front());
        end
    endtask

    // Monitor: frames complete 8 clocks after ss rises; display phase follows the scan timing of the spec
    initial begin
        logic ps = 1, pk = 1, act = 0;
        logic [31:0] w = 0;
        int ec = 0, tail = 0;
        frame_t f;
        disp_t d;
        forever begin
            @(negedge clk);
            if (ferr) ec++;
            if (!ss && ps) begin w = 0; ec = 0; act = 1; end
            if (act && !ss && sclk && !pk) w = {w[30:0], miso};
            if (act && ss && !ps) tail = 8;
            if (tail > 0) begin
                tail--;
                if (tail == 0) begin
                    act = 0;
                    if (fq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected frame: got %h", w);
                    end else begin
                        f = fq.pop_front();
                        chk({f.name, " miso"}, w, f.miso);
                        chk({f.name, " frame_err count"}, ec, f.errs);
                    end
                end
            end
            if (cyc > 0 && dq.size() > 0 && ((cyc - 1) / SD) % ND == dq[0].idx) begin
                d = dq.pop_front();
                chk({d.name, " digit"}, {24'h0, dig}, {24'h0, d.dig});
                chk({d.name, " segment"}, {24'h0, seg}, {24'h0, d.seg});
            end
            ps = ss;
            pk = sclk;
        end
    end

    initial begin
        rst_n = 0; ss = 1; sclk = 1; mosi = 0;
        #22;
        chk("reset digit", {24'h0, dig}, 32'hFF);
        chk("reset segment", {24'h0, seg}, 32'hFF);
        chk("reset miso", {31'h0, miso}, 32'h1);
        chk("reset frame_err", {31'h0, ferr}, 32'h0);
        #20 rst_n = 1;
        #(2 * SD * ND * 10);
        chk("idle miso", {31'h0, miso}, 32'h1);
        disp(0, 8'hFF, 8'hFF, "idle idx0");
        disp(3, 8'hFF, 8'hFF, "idle idx3");
        settle();

        wr(16'h10FF, "wr enable");
        wr(16'h1105, "wr digit0");
        wr(16'h1901, "wr radix");
        disp(0, 8'hFE, 8'h12, "digit0 shows 5");
        disp(1, 8'hFD, 8'hC0, "digit1 shows 0");
        settle();

        send(32'h120, 12, 32'hFFF, 1, "short frame");
        disp(1, 8'hFD, 8'hC0, "reg2 unchanged");
        settle();
        send(32'h0, 17, 32'h1FFFF, 1, "17-bit frame");

        wr(16'h1333, "wr digit2");
        disp(2, 8'hFB, 8'hB0, "digit2 shows 3");
        settle();
        wr(16'h3000, "clear");
        disp(0, 8'hFF, 8'hFF, "cleared idx0");
        disp(2, 8'hFF, 8'hFF, "cleared idx2");
        settle();

        wr(16'h14A7, "wr digit3");
        wr(16'h2400, "rd reg4");
        send(32'h0, 16, RB_A7, 0, "readback reg4");
        send(32'h0, 16, 32'hFFFF, 0, "readback cleared");
        wr(16'h2F00, "rd addr15");
        send(32'h0, 16, RB_00, 0, "readback addr15");

        wr(16'h1002, "wr enable digit1");
        wr(16'h1F12, "wr addr15");
        disp(1, 8'hFD, 8'hC0, "addr15 ignored idx1");
        disp(0, 8'hFF, 8'hFF, "addr15 ignored idx0");
        disp(3, 8'hFF, 8'hFF, "disabled digit3");
        settle();

        for (int i = 0; i < 50 && fq.size() > 0; i++) #10;
        while (fq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: frame never completed", fq[0].name);
            void'(fq.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
